bitrev_reorder_buf: RTL and testbench



---
 rtl/fft_pkg.sv | 26 ++
 rtl/bitrev_addr.sv | 18 +
 rtl/bitrev_reorder_buf.sv | 123 ++++++++++++
 tb/tb_bitrev_reorder_buf.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT input reorder path.
//   DEF_DATA_W / DEF_LOG2N : default sample width and log2 frame length
//   bank_state_e           : ping-pong bank occupancy state
//   bitrev()               : index bit reversal for reference models
package fft_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_LOG2N  = 4;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  function automatic int unsigned bitrev(input int unsigned idx,
                                         input int unsigned nbits);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < nbits; k++) begin
      if (idx[nbits-1-k]) r[k] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bitrev_addr.sv
// bitrev_addr: combinational address bit reversal.
//   i_addr : natural-order index (LOG2N bits)
//   o_addr : bit-reversed index, bit k = i_addr bit LOG2N-1-k
module bitrev_addr #(
  parameter int LOG2N = 4
) (
  input  logic [LOG2N-1:0] i_addr,
  output logic [LOG2N-1:0] o_addr
);

  always_comb begin
    o_addr = '0;
    for (int unsigned k = 0; k < LOG2N; k++) begin
      o_addr[k] = i_addr[LOG2N-1-k];
    end
  end

endmodule

// File: rtl/bitrev_reorder_buf.sv
// bitrev_reorder_buf: two-bank (ping-pong) reorder buffer. Accepts an
// N = 2**LOG2N sample frame in natural order and emits it in bit-reversed
// index order through a single output register; one bank fills while the
// other drains.
// Optional build macro BITREV_NATURAL_MODE_EN adds mode_nat: sampled on the
// first accept of a frame, a natural-tagged bank is drained in order.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   mode_nat              : (macro only) per-frame passthrough select
//   in_valid/in_ready     : input handshake, in_data natural order
//   out_valid/out_ready   : output handshake, out_data bit-reversed order
//   out_last              : final sample of a frame
module bitrev_reorder_buf
  import fft_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LOG2N  = DEF_LOG2N
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef BITREV_NATURAL_MODE_EN
  input  logic              mode_nat,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int N = 1 << LOG2N;

  logic [DATA_W-1:0] r_mem [2][N];
  bank_state_e       r_state [2];
  bank_state_e       w_state_nxt [2];
  logic              r_wr_bank, r_rd_bank;
  logic [LOG2N-1:0]  r_wr_cnt, r_rd_cnt;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid, r_out_last;

  logic              w_wr_en, w_rd_en, w_wr_last, w_rd_last;
  logic [LOG2N-1:0]  w_rev_addr, w_rd_addr;

  assign in_ready  = (r_state[r_wr_bank] != BANK_FULL);
  assign w_wr_en   = in_valid && in_ready;
  assign w_wr_last = (r_wr_cnt == '1);
  assign w_rd_en   = (r_state[r_rd_bank] == BANK_FULL) && (!r_out_valid || out_ready);
  assign w_rd_last = (r_rd_cnt == '1);

  bitrev_addr #(.LOG2N(LOG2N)) u_bitrev_addr (
    .i_addr (r_rd_cnt),
    .o_addr (w_rev_addr)
  );

`ifdef BITREV_NATURAL_MODE_EN
  logic r_nat [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nat[0] <= 1'b0;
      r_nat[1] <= 1'b0;
    end else if (w_wr_en && (r_wr_cnt == '0)) begin
      r_nat[r_wr_bank] <= mode_nat;
    end
  end

  assign w_rd_addr = r_nat[r_rd_bank] ? r_rd_cnt : w_rev_addr;
`else
  assign w_rd_addr = w_rev_addr;
`endif

  // A write needs a non-FULL bank and a read needs a FULL bank, so the two
  // updates can never target the same bank in one cycle.
  always_comb begin
    w_state_nxt[0] = r_state[0];
    w_state_nxt[1] = r_state[1];
    if (w_wr_en) w_state_nxt[r_wr_bank] = w_wr_last ? BANK_FULL : BANK_FILLING;
    if (w_rd_en && w_rd_last) w_state_nxt[r_rd_bank] = BANK_EMPTY;
  end

  // Sample storage is not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_bank][r_wr_cnt] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state[0]  <= BANK_EMPTY;
      r_state[1]  <= BANK_EMPTY;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
      if (w_wr_en) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (w_wr_last) r_wr_bank <= ~r_wr_bank;
      end
      if (w_rd_en) begin
        r_out_data  <= r_mem[r_rd_bank][w_rd_addr];
        r_out_valid <= 1'b1;
        r_out_last  <= w_rd_last;
        r_rd_cnt    <= r_rd_cnt + 1'b1;
        if (w_rd_last) r_rd_bank <= ~r_rd_bank;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// tb_bitrev_reorder_buf: directed bench for bitrev_reorder_buf at the
// default parameters (DATA_W=16, LOG2N=4). When BITREV_NATURAL_MODE_EN is
// defined the bench also drives mode_nat and exercises passthrough.
module tb_bitrev_reorder_buf;
  import fft_pkg::*;

  localparam int DW = 16;
  localparam int LG = 4;
  localparam int N  = 16;

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          last;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
`ifdef BITREV_NATURAL_MODE_EN
  logic          mode_nat = 1'b0;
`endif

  bitrev_reorder_buf #(.DATA_W(DW), .LOG2N(LG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef BITREV_NATURAL_MODE_EN
    .mode_nat  (mode_nat),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   nrun  = 0;
  int   nfail = 0;
  vec_t tbl [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nrun++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, mid-cycle.
  logic [DW-1:0] got_d [$];
  logic          got_l [$];
  int unsigned   got_c [$];
  bit            mon_stall = 1'b0;
  logic [DW-1:0] mon_d;
  logic          mon_l;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_stall = 1'b0;
    end else begin
      if (mon_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data",  32'(out_data),  32'(mon_d));
        check("stall_last",  32'(out_last),  32'(mon_l));
      end
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
        got_c.push_back(cyc);
      end
      mon_stall = out_valid && !out_ready;
      mon_d     = out_data;
      mon_l     = out_last;
    end
  end

  task automatic clear_q();
    got_d.delete();
    got_l.delete();
    got_c.delete();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear_q();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Present one sample and hold it until accepted; waits = stalled cycles.
  task automatic push(input logic [DW-1:0] d, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waits < 200) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic push_frame(input logic [DW-1:0] base, output int waits_sum);
    int w;
    waits_sum = 0;
    for (int i = 0; i < N; i++) begin
      push(base + tbl[i].din, w);
      waits_sum += w;
    end
  endtask

  task automatic wait_outputs(input int n);
    int budget;
    budget = 300;
    while (got_d.size() < n && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("drain_count", 32'(got_d.size()), 32'(n));
    repeat (20) @(posedge clk);
    #1;
    check("no_extra_output", 32'(got_d.size()), 32'(n));
  endtask

  task automatic check_frame(input int start, input logic [DW-1:0] base, input bit nat);
    logic [DW-1:0] e;
    for (int k = 0; k < N; k++) begin
      if (start + k >= got_d.size()) return;
      e = nat ? base + DW'(k) : base + tbl[k].dout;
      check("frame_data", 32'(got_d[start+k]), 32'(e));
      check("frame_last", 32'(got_l[start+k]), 32'(tbl[k].last));
    end
  endtask

  initial begin
    int unsigned rev_tab [N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int w, wsum, bubbles, n;

    for (int i = 0; i < N; i++) begin
      tbl[i].din  = DW'(i);
      tbl[i].dout = DW'(rev_tab[i]);
      tbl[i].last = (i == N - 1);
    end

    // Reset state, during and after reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid2", 32'(out_valid), 32'd0);

    // Single frame, table-driven; first output one edge after the FULL edge
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      push(tbl[i].din, w);
      check("single_no_wait", 32'(w), 32'd0);
    end
    check("latency_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("latency_valid", 32'(out_valid), 32'd1);
    check("latency_data",  32'(out_data),  32'd0);
    wait_outputs(N);
    check_frame(0, 16'd0, 1'b0);

    // Ping-pong: two frames back-to-back, no input stall, no output bubble
    do_reset();
    out_ready = 1'b1;
    push_frame(16'd0, wsum);
    push_frame(16'd100, n);
    check("pingpong_in_ready_drops", 32'(wsum + n), 32'd0);
    wait_outputs(2 * N);
    check_frame(0, 16'd0, 1'b0);
    check_frame(N, 16'd100, 1'b0);
    bubbles = 0;
    for (int k = 1; k < got_c.size(); k++)
      if (got_c[k] != got_c[k-1] + 1) bubbles++;
    check("pingpong_bubbles", 32'(bubbles), 32'd0);

    // Full stall: both banks full with output held, then release
    do_reset();
    out_ready = 1'b0;
    push_frame(16'd0, wsum);
    push_frame(16'd16, n);
    check("stall_fill_waits", 32'(wsum + n), 32'd0);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_out_data", 32'(out_data), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("stall_in_ready_held", 32'(in_ready), 32'd0);
    check("stall_out_data_held", 32'(out_data), 32'd0);
    // 15 more loads drain bank 0; it is writable the cycle after the last one
    in_valid  = 1'b1;
    in_data   = 16'd99;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_resume_edges", 32'(n), 32'd15);
    push(16'd99, w);
    check("stall_33rd_immediate", 32'(w), 32'd0);
    wait_outputs(2 * N);
    check_frame(0, 16'd0, 1'b0);
    check_frame(N, 16'd16, 1'b0);

    // Backpressure: out_ready toggles every cycle while draining
    do_reset();
    push_frame(16'd200, wsum);
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 40; c++) begin
      out_ready = ~out_ready;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_outputs(N);
    check_frame(0, 16'd200, 1'b0);

    // Mid-frame reset discards the partial frame
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) push(16'(50 + i), w);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    clear_q();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    push_frame(16'd0, wsum);
    wait_outputs(N);
    check_frame(0, 16'd0, 1'b0);

`ifdef BITREV_NATURAL_MODE_EN
    // Natural-order passthrough frame followed by a bit-reversed one
    do_reset();
    out_ready = 1'b1;
    mode_nat  = 1'b1;
    push_frame(16'd0, wsum);
    mode_nat  = 1'b0;
    push_frame(16'd300, n);
    wait_outputs(2 * N);
    check_frame(0, 16'd0, 1'b1);
    check_frame(N, 16'd300, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
